// File: rtl/game_session_ctrl.sv
// game_session_ctrl: game-flow controller for the VGA game.
// Tracks IDLE/RUN/PAUSE/OVER, a lives counter, an elapsed-seconds timer
// and an inactivity timeout that auto-pauses a running game.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   act[N_SRC]        activity strobes, any bit high = player input
//   pause_btn         pause button level, rising edge pauses/resumes
//   end_evt           life-lost strobe
//   restart           restart level, returns PAUSE/OVER to IDLE
//   state             IDLE=00 RUN=01 PAUSE=10 OVER=11
//   running           high iff state==RUN
//   lives_left        remaining lives
//   elapsed_s         seconds spent in RUN, saturating
//   over_pulse        one-cycle pulse on entry to OVER
//   timeout_pulse     one-cycle pulse on a timeout-triggered pause
module game_session_ctrl #(
  parameter int unsigned N_SRC          = 3,
  parameter int unsigned TICK_CYCLES    = 100_000_000,
  parameter int unsigned IDLE_TIMEOUT_S = 30,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned SEC_W          = 12,
  localparam int unsigned LW            = $clog2(LIVES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] act,
  input  logic             pause_btn,
  input  logic             end_evt,
  input  logic             restart,
  output logic [1:0]       state,
  output logic             running,
  output logic [LW-1:0]    lives_left,
  output logic [SEC_W-1:0] elapsed_s,
  output logic             over_pulse,
  output logic             timeout_pulse
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned IW = (IDLE_TIMEOUT_S > 0) ? $clog2(IDLE_TIMEOUT_S + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t           state_q, state_nxt;
  logic             pause_q;
  logic [TW-1:0]    tick_q, tick_nxt;
  logic [IW-1:0]    idle_q, idle_nxt;
  logic [LW-1:0]    lives_nxt;
  logic [SEC_W-1:0] elapsed_nxt;
  logic             running_nxt, over_nxt, timeout_nxt;

  logic any_act, pause_edge, sec_tick, timeout_hit, last_life;

  assign any_act    = |act;
  assign pause_edge = pause_btn & ~pause_q;
  // The wrap of the cycle counter marks one game second.
  assign sec_tick   = (state_q == S_RUN) && (tick_q == TW'(TICK_CYCLES - 1));
  // Timeout fires on the second that would bring idle_s up to the limit.
  assign timeout_hit = sec_tick && !any_act &&
                       ((32'(idle_q) + 32'd1) >= IDLE_TIMEOUT_S);
  assign last_life  = (lives_left <= LW'(1));

  assign state = 2'(state_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE:  if (any_act) state_nxt = S_RUN;
      S_RUN: begin
        if (end_evt) begin
          if (last_life) state_nxt = S_OVER;
        end else if (pause_edge || timeout_hit) begin
          state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (restart)                      state_nxt = S_IDLE;
        else if (pause_edge || any_act)   state_nxt = S_RUN;
      end
      S_OVER:  if (restart) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    tick_nxt    = tick_q;
    idle_nxt    = idle_q;
    lives_nxt   = lives_left;
    elapsed_nxt = elapsed_s;
    over_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    running_nxt = (state_nxt == S_RUN);
    unique case (state_q)
      S_IDLE: begin
        if (any_act) begin
          lives_nxt   = LW'(LIVES);
          elapsed_nxt = '0;
          tick_nxt    = '0;
          idle_nxt    = '0;
        end
      end
      S_RUN: begin
        tick_nxt = sec_tick ? '0 : tick_q + TW'(1);
        if (sec_tick && (elapsed_s != '1)) elapsed_nxt = elapsed_s + SEC_W'(1);
        // Activity clears the idle count even on a second boundary.
        if (any_act)
          idle_nxt = '0;
        else if (sec_tick && (32'(idle_q) < IDLE_TIMEOUT_S))
          idle_nxt = idle_q + IW'(1);
        if (end_evt) begin
          if (last_life) begin
            lives_nxt = '0;
            over_nxt  = 1'b1;
          end else begin
            lives_nxt = lives_left - LW'(1);
          end
        end else if (!pause_edge && timeout_hit) begin
          idle_nxt    = '0;
          timeout_nxt = 1'b1;
        end
      end
      S_PAUSE: begin
        if (!restart && (pause_edge || any_act)) idle_nxt = '0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_q       <= 1'b0;
      tick_q        <= '0;
      idle_q        <= '0;
      lives_left    <= '0;
      elapsed_s     <= '0;
      running       <= 1'b0;
      over_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      pause_q       <= pause_btn;
      tick_q        <= tick_nxt;
      idle_q        <= idle_nxt;
      lives_left    <= lives_nxt;
      elapsed_s     <= elapsed_nxt;
      running       <= running_nxt;
      over_pulse    <= over_nxt;
      timeout_pulse <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench for game_session_ctrl with TICK_CYCLES=4,
// IDLE_TIMEOUT_S=2, LIVES=2.
module tb_game_session_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  act;
  logic        pause_btn;
  logic        end_evt;
  logic        restart;
  logic [1:0]  state;
  logic        running;
  logic [1:0]  lives_left;
  logic [11:0] elapsed_s;
  logic        over_pulse;
  logic        timeout_pulse;

  int n_chk;
  int n_fail;

  game_session_ctrl #(
    .N_SRC(3), .TICK_CYCLES(4), .IDLE_TIMEOUT_S(2), .LIVES(2), .SEC_W(12)
  ) dut (
    .clk(clk), .rst(rst), .act(act), .pause_btn(pause_btn),
    .end_evt(end_evt), .restart(restart), .state(state), .running(running),
    .lives_left(lives_left), .elapsed_s(elapsed_s), .over_pulse(over_pulse),
    .timeout_pulse(timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  act;
    logic        pb;
    logic        ev;
    logic        rs;
    logic [1:0]  st;
    logic [1:0]  lv;
    logic [11:0] el;
    logic        op;
    logic        tp;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic pb, input logic ev, input logic rs);
    @(negedge clk);
    act = a; pause_btn = pb; end_evt = ev; restart = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " state"},   32'(state), 32'd0);
    check({tag, " running"}, 32'(running), 32'd0);
    check({tag, " lives"},   32'(lives_left), 32'd0);
    check({tag, " elapsed"}, 32'(elapsed_s), 32'd0);
    check({tag, " over"},    32'(over_pulse), 32'd0);
    check({tag, " timeout"}, 32'(timeout_pulse), 32'd0);
  endtask

  initial begin
    int entries;
    logic [1:0] prev_st;
    n_chk = 0; n_fail = 0;

    //          act     pb    ev    rs    st     lv     el      op    tp
    tbl[0]  = '{3'b010, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 12'd0, 1'b0, 1'b0};
    tbl[1]  = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 12'd0, 1'b0, 1'b0};
    tbl[2]  = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 12'd0, 1'b0, 1'b0};
    tbl[3]  = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 12'd0, 1'b0, 1'b0};
    tbl[4]  = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 12'd1, 1'b0, 1'b0};
    tbl[5]  = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 12'd1, 1'b0, 1'b0};
    tbl[6]  = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 12'd1, 1'b0, 1'b0};
    tbl[7]  = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 12'd1, 1'b0, 1'b0};
    tbl[8]  = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 12'd2, 1'b0, 1'b1};
    tbl[9]  = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 12'd2, 1'b0, 1'b0};
    tbl[10] = '{3'b001, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 12'd2, 1'b0, 1'b0};
    tbl[11] = '{3'b001, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 12'd2, 1'b0, 1'b0};
    tbl[12] = '{3'b000, 1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 12'd2, 1'b0, 1'b0};
    tbl[13] = '{3'b000, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 12'd2, 1'b1, 1'b0};
    tbl[14] = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 12'd2, 1'b0, 1'b0};
    tbl[15] = '{3'b111, 1'b1, 1'b1, 1'b0, 2'd3, 2'd0, 12'd2, 1'b0, 1'b0};
    tbl[16] = '{3'b000, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 12'd2, 1'b0, 1'b0};
    tbl[17] = '{3'b100, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 12'd0, 1'b0, 1'b0};
    tbl[18] = '{3'b000, 1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 12'd0, 1'b0, 1'b0};
    tbl[19] = '{3'b000, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 12'd0, 1'b0, 1'b0};
    tbl[20] = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 12'd0, 1'b0, 1'b0};
    tbl[21] = '{3'b000, 1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 12'd1, 1'b0, 1'b0};
    tbl[22] = '{3'b010, 1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 12'd1, 1'b0, 1'b0};

    rst = 1'b1; act = '0; pause_btn = 1'b0; end_evt = 1'b0; restart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].act, tbl[i].pb, tbl[i].ev, tbl[i].rs);
      check($sformatf("vec%0d state", i),   32'(state), 32'(tbl[i].st));
      check($sformatf("vec%0d running", i), 32'(running), 32'(tbl[i].st == 2'd1));
      check($sformatf("vec%0d lives", i),   32'(lives_left), 32'(tbl[i].lv));
      check($sformatf("vec%0d elapsed", i), 32'(elapsed_s), 32'(tbl[i].el));
      check($sformatf("vec%0d over", i),    32'(over_pulse), 32'(tbl[i].op));
      check($sformatf("vec%0d timeout", i), 32'(timeout_pulse), 32'(tbl[i].tp));
    end

    // Held pause button produces a single PAUSE entry.
    drive(3'b001, 1'b0, 1'b0, 1'b0);
    check("hold start state", 32'(state), 32'd1);
    check("hold start lives", 32'(lives_left), 32'd2);
    entries = 0;
    for (int c = 0; c < 10; c++) begin
      prev_st = state;
      drive(3'b000, 1'b1, 1'b0, 1'b0);
      if (prev_st != 2'd2 && state == 2'd2) entries++;
    end
    check("hold pause entries", 32'(entries), 32'd1);
    check("hold final state", 32'(state), 32'd2);
    drive(3'b000, 1'b0, 1'b0, 1'b0);
    check("release state", 32'(state), 32'd2);
    drive(3'b000, 1'b1, 1'b0, 1'b0);
    check("repress state", 32'(state), 32'd1);
    check("repress elapsed", 32'(elapsed_s), 32'd0);

    // Run across one second, then reset asynchronously mid-cycle.
    repeat (4) drive(3'b000, 1'b0, 1'b0, 1'b0);
    check("pre-reset state", 32'(state), 32'd1);
    check("pre-reset elapsed", 32'(elapsed_s), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("async reset");
    @(negedge clk);
    rst = 1'b0;
    drive(3'b010, 1'b0, 1'b0, 1'b0);
    check("post-reset state", 32'(state), 32'd1);
    check("post-reset lives", 32'(lives_left), 32'd2);
    check("post-reset elapsed", 32'(elapsed_s), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
